// File: rtl/idct_pass_sequencer.sv
// Two-pass 8x8 IDCT sequencer: pass 1 fills temp RAM, pass 2 writes output; writes lag reads by RD_LAT.
// Latency start->done 2*(64+RD_LAT)+1 cycles; stall freezes pass-2 issue and the whole write pipe.
module idct_pass_sequencer #(
    parameter int IDX_W  = 3,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic             pass_sel,
    output logic [IDX_W-1:0] rd_i,
    output logic [IDX_W-1:0] rd_j,
    output logic             wen_temp,
    output logic             wen_out,
    output logic [IDX_W-1:0] wr_i,
    output logic [IDX_W-1:0] wr_j
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PASS1,
        S_DRAIN1,
        S_PASS2,
        S_DRAIN2,
        S_DONE
    } state_t;

    typedef struct packed {
        logic             vld;
        logic             pass;
        logic [IDX_W-1:0] i;
        logic [IDX_W-1:0] j;
    } pipe_t;

    localparam logic [IDX_W-1:0] IDX_MAX    = '1;
    localparam logic [2:0]       DRAIN_LAST = 3'(RD_LAT - 1);

    state_t     state;
    logic [2:0] dcnt;
    pipe_t      pipe [RD_LAT];
    pipe_t      tail;
    logic       stall_act;
    logic       issue;
    logic       last_idx;

    assign stall_act = stall & ((state == S_PASS2) | (state == S_DRAIN2));
    assign issue     = (state == S_PASS1) | (state == S_PASS2);
    assign last_idx  = (rd_i == IDX_MAX) & (rd_j == IDX_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            dcnt     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass_sel <= 1'b0;
            rd_i     <= '0;
            rd_j     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_PASS1;
                        busy     <= 1'b1;
                        pass_sel <= 1'b0;
                        rd_i     <= '0;
                        rd_j     <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_PASS1, S_PASS2: begin
                    if (!stall_act) begin
                        // rd_* keeps the final (max,max) index while draining
                        if (last_idx) begin
                            state <= (state == S_PASS1) ? S_DRAIN1 : S_DRAIN2;
                            dcnt  <= '0;
                        end else begin
                            rd_j <= rd_j + IDX_W'(1);
                            if (rd_j == IDX_MAX) begin
                                rd_i <= rd_i + IDX_W'(1);
                            end
                        end
                    end
                end
                S_DRAIN1: begin
                    if (dcnt == DRAIN_LAST) begin
                        state    <= S_PASS2;
                        pass_sel <= 1'b1;
                        rd_i     <= '0;
                        rd_j     <= '0;
                    end else begin
                        dcnt <= dcnt + 3'd1;
                    end
                end
                S_DRAIN2: begin
                    if (!stall_act) begin
                        if (dcnt == DRAIN_LAST) begin
                            state    <= S_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass_sel <= 1'b0;
                        end else begin
                            dcnt <= dcnt + 3'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write pipe mirrors datapath read latency; frozen as a whole while the sink stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pipe[k] <= '0;
            end
        end else if (!stall_act) begin
            pipe[0] <= {issue, pass_sel, rd_i, rd_j};
            for (int k = 1; k < RD_LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign tail     = pipe[RD_LAT-1];
    assign wen_temp = tail.vld & ~tail.pass;
    assign wen_out  = tail.vld & tail.pass & ~stall_act;
    assign wr_i     = tail.i;
    assign wr_j     = tail.j;

endmodule

// File: tb/tb_idct_pass_sequencer.sv
// Scoreboard bench: RD_LAT=1 and RD_LAT=3 instances share start/rst; each has its own stall.
module tb_idct_pass_sequencer;

    localparam int BIG = 1 << 30;

    typedef struct {
        int kind;
        int i;
        int j;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stall1 = 1'b0;
    logic stall3 = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    ev_t  q1[$];
    ev_t  q3[$];

    logic       busy1, done1, pass_sel1, wen_temp1, wen_out1;
    logic [2:0] rd_i1, rd_j1, wr_i1, wr_j1;
    logic       busy3, done3, pass_sel3, wen_temp3, wen_out3;
    logic [2:0] rd_i3, rd_j3, wr_i3, wr_j3;

    idct_pass_sequencer #(.IDX_W(3), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start), .stall(stall1),
        .busy(busy1), .done(done1), .pass_sel(pass_sel1),
        .rd_i(rd_i1), .rd_j(rd_j1), .wen_temp(wen_temp1), .wen_out(wen_out1),
        .wr_i(wr_i1), .wr_j(wr_j1)
    );

    idct_pass_sequencer #(.IDX_W(3), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .start(start), .stall(stall3),
        .busy(busy3), .done(done3), .pass_sel(pass_sel3),
        .rd_i(rd_i3), .rd_j(rd_j3), .wen_temp(wen_temp3), .wen_out(wen_out3),
        .wr_i(wr_i3), .wr_j(wr_j3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic add(input int sel, input int kind, input int i, input int j, input int c);
        ev_t e;
        e.kind = kind;
        e.i    = i;
        e.j    = j;
        e.cyc  = c;
        if (sel == 0) q1.push_back(e);
        else q3.push_back(e);
    endtask

    // Expected writes/done for a block started at t; s = first stalled cycle (5-cycle stall),
    // lim = last cycle before an aborting reset takes effect.
    task automatic push_block(input int sel, input int t, input int lat, input int s, input int lim);
        int c;
        for (int k = 0; k < 64; k++) begin
            c = t + 1 + k + lat;
            if (s != 0 && c >= s) c += 5;
            if (c <= lim) add(sel, 0, k / 8, k % 8, c);
        end
        for (int k = 0; k < 64; k++) begin
            c = t + 1 + 64 + lat + k + lat;
            if (s != 0 && c >= s) c += 5;
            if (c <= lim) add(sel, 1, k / 8, k % 8, c);
        end
        c = t + 1 + 64 + lat + 64 + lat;
        if (s != 0 && c >= s) c += 5;
        if (c <= lim) add(sel, 2, 0, 0, c);
    endtask

    task automatic sb_cmp(input string nm, input int has_exp, input ev_t a, input ev_t e);
        n_tests++;
        if (has_exp == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected kind=%0d (%0d,%0d) @%0d", nm, a.kind, a.i, a.j, a.cyc);
        end else if (a.kind != e.kind || a.i != e.i || a.j != e.j || a.cyc != e.cyc) begin
            n_fail++;
            $display("FAIL %s: got kind=%0d (%0d,%0d) @%0d expected kind=%0d (%0d,%0d) @%0d",
                     nm, a.kind, a.i, a.j, a.cyc, e.kind, e.i, e.j, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        ev_t a, e;
        int  has;
        if (wen_temp1 || wen_out1 || done1) begin
            a.kind = done1 ? 2 : (wen_out1 ? 1 : 0);
            a.i    = done1 ? 0 : int'(wr_i1);
            a.j    = done1 ? 0 : int'(wr_j1);
            a.cyc  = cyc;
            has    = (q1.size() != 0) ? 1 : 0;
            e      = a;
            if (has != 0) e = q1.pop_front();
            sb_cmp("sb_lat1", has, a, e);
        end
    end

    always @(negedge clk) begin
        ev_t a, e;
        int  has;
        if (wen_temp3 || wen_out3 || done3) begin
            a.kind = done3 ? 2 : (wen_out3 ? 1 : 0);
            a.i    = done3 ? 0 : int'(wr_i3);
            a.j    = done3 ? 0 : int'(wr_j3);
            a.cyc  = cyc;
            has    = (q3.size() != 0) ? 1 : 0;
            e      = a;
            if (has != 0) e = q3.pop_front();
            sb_cmp("sb_lat3", has, a, e);
        end
    end

    initial begin
        // Reset state
        goto(3);
        rst = 1'b0;
        goto(4);
        check("rst_outs_lat1", int'({busy1, done1, pass_sel1, rd_i1, rd_j1, wen_temp1, wen_out1, wr_i1, wr_j1}), 0);
        check("rst_outs_lat3", int'({busy3, done3, pass_sel3, rd_i3, rd_j3, wen_temp3, wen_out3, wr_i3, wr_j3}), 0);

        // Basic block at T=10 with stall toggled during IDLE/PASS1 (must be ignored)
        push_block(0, 10, 1, 0, BIG);
        push_block(1, 10, 3, 0, BIG);
        goto(7);
        stall1 = 1'b1;
        stall3 = 1'b1;
        goto(10);
        check("idle_busy_lat1", int'(busy1), 0);
        start = 1'b1;
        goto(11);
        start = 1'b0;
        check("p1_busy_lat1", int'(busy1), 1);
        check("p1_busy_lat3", int'(busy3), 1);
        check("p1_pass_sel", int'(pass_sel1), 0);
        check("p1_first_rd", int'({rd_i1, rd_j1}), 0);
        goto(65);
        stall1 = 1'b0;
        stall3 = 1'b0;
        goto(75);
        check("drain1_rd_hold", int'({rd_i1, rd_j1}), 63);
        check("drain1_busy", int'(busy1), 1);
        goto(76);
        check("p2_pass_sel", int'(pass_sel1), 1);
        check("p2_first_rd", int'({rd_i1, rd_j1}), 0);
        goto(140);
        check("drain2_busy", int'(busy1), 1);
        goto(141);
        check("done_busy_lat1", int'(busy1), 0);
        goto(146);
        check("idle_busy_lat3", int'(busy3), 0);

        // Five-cycle stall at pass-2 index (3,4)
        push_block(0, 160, 1, 254, BIG);
        push_block(1, 160, 3, 256, BIG);
        goto(160);
        start = 1'b1;
        goto(161);
        start = 1'b0;
        goto(254);
        stall1 = 1'b1;
        check("stall_rd_lat1", int'({rd_i1, rd_j1}), 28);
        goto(256);
        stall3 = 1'b1;
        check("stall_rd_lat3", int'({rd_i3, rd_j3}), 28);
        goto(258);
        check("stall_hold_lat1", int'({rd_i1, rd_j1}), 28);
        goto(259);
        stall1 = 1'b0;
        goto(261);
        stall3 = 1'b0;
        goto(296);
        check("stall_done_busy", int'(busy1), 0);

        // start held high: back-to-back blocks, mid-block start ignored
        push_block(0, 320, 1, 0, BIG);
        push_block(0, 451, 1, 0, BIG);
        push_block(1, 320, 3, 0, BIG);
        push_block(1, 455, 3, 0, BIG);
        goto(320);
        start = 1'b1;
        goto(451);
        check("b2b_done_busy", int'(busy1), 0);
        goto(452);
        check("b2b_restart_busy", int'(busy1), 1);
        check("b2b_restart_rd", int'({rd_i1, rd_j1, pass_sel1}), 0);
        goto(500);
        start = 1'b0;

        // Reset mid-PASS1 at (2,5): abort without done, then rst+start together
        push_block(0, 620, 1, 0, 642);
        push_block(1, 620, 3, 0, 642);
        goto(620);
        start = 1'b1;
        goto(621);
        start = 1'b0;
        goto(642);
        check("abort_rd", int'({rd_i1, rd_j1}), 21);
        rst = 1'b1;
        goto(643);
        rst = 1'b0;
        check("abort_outs_lat1", int'({busy1, done1, pass_sel1, rd_i1, rd_j1, wen_temp1, wen_out1, wr_i1, wr_j1}), 0);
        check("abort_outs_lat3", int'({busy3, done3, pass_sel3, rd_i3, rd_j3, wen_temp3, wen_out3, wr_i3, wr_j3}), 0);
        goto(650);
        rst = 1'b1;
        start = 1'b1;
        goto(651);
        rst = 1'b0;
        start = 1'b0;
        check("rst_wins_lat1", int'(busy1), 0);
        check("rst_wins_lat3", int'(busy3), 0);

        // Clean restart after abort
        push_block(0, 660, 1, 0, BIG);
        push_block(1, 660, 3, 0, BIG);
        goto(660);
        start = 1'b1;
        goto(661);
        start = 1'b0;
        goto(820);
        check("sb_drained_lat1", q1.size(), 0);
        check("sb_drained_lat3", q3.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
